// File: rtl/rolling_variance.sv
// Rolling-window population variance over 2^LOG2_WINDOW prices; drives the fixed-point sqrt.
// Optional ROLLING_VARIANCE_MEAN_OUT_EN adds o_mean, the window mean registered alongside o_rad.
module rolling_variance #(
   parameter int WIDTH       = 32,
   parameter int FRACT_BITS  = 16,
   parameter int LOG2_WINDOW = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_price,
   output logic             o_start,
   output logic [WIDTH-1:0] o_rad,
   input  logic             i_sqrt_busy,
   input  logic             i_sqrt_valid,
   output logic             o_warm,
   output logic             o_overflow
`ifdef ROLLING_VARIANCE_MEAN_OUT_EN
   ,
   output logic [WIDTH-1:0] o_mean
`endif
);
   // state  | meaning
   // IDLE   | ready; accept a sample, swap it into the circular buffer
   // UPDATE | fold new and evicted sample into sum / sumsq
   // CALC   | derive variance radicand (saturating) from sum / sumsq
   // ISSUE  | wait for sqrt idle, then pulse o_start
   // WAIT   | hold off samples until sqrt reports valid

   localparam int L     = LOG2_WINDOW;
   localparam int DEPTH = 1 << L;
   localparam int SW    = WIDTH + L;
   localparam int PW    = 2 * WIDTH;
   localparam int QW    = 2 * WIDTH + L;

   typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_CALC, S_ISSUE, S_WAIT} state_t;

   state_t           state;
   logic [WIDTH-1:0] sample_mem [DEPTH];
   logic [L-1:0]     wptr;
   logic [L:0]       fill;
   logic [WIDTH-1:0] new_r;
   logic [WIDTH-1:0] old_r;
   logic [SW-1:0]    sum;
   logic [QW-1:0]    sumsq;

   logic             accept;
   logic [PW-1:0]    new_sq;
   logic [PW-1:0]    old_sq;
   logic [WIDTH-1:0] mean;
   logic [PW-1:0]    mean_sq;
   logic [PW-1:0]    ex2;
   logic [PW-1:0]    var_raw;
   logic [PW-1:0]    var_scaled;
   logic             var_sat;

   assign accept = i_valid && o_ready;

   always_comb begin
      new_sq     = {{WIDTH{1'b0}}, new_r} * {{WIDTH{1'b0}}, new_r};
      old_sq     = {{WIDTH{1'b0}}, old_r} * {{WIDTH{1'b0}}, old_r};
      mean       = WIDTH'(sum >> L);
      ex2        = PW'(sumsq >> L);
      mean_sq    = {{WIDTH{1'b0}}, mean} * {{WIDTH{1'b0}}, mean};
      // Truncated mean/E[x^2] can in principle invert; clamp at zero.
      var_raw    = (mean_sq > ex2) ? '0 : (ex2 - mean_sq);
      var_scaled = var_raw >> FRACT_BITS;
      var_sat    = |var_scaled[PW-1:WIDTH];
   end

   // Buffer contents are don't-care until the window first fills.
   always_ff @(posedge i_clk) begin
      if (state == S_IDLE && accept) begin
         sample_mem[wptr] <= i_price;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= S_IDLE;
         o_ready    <= 1'b1;
         o_start    <= 1'b0;
         o_rad      <= '0;
         o_warm     <= 1'b0;
         o_overflow <= 1'b0;
         wptr       <= '0;
         fill       <= '0;
         new_r      <= '0;
         old_r      <= '0;
         sum        <= '0;
         sumsq      <= '0;
`ifdef ROLLING_VARIANCE_MEAN_OUT_EN
         o_mean     <= '0;
`endif
      end else begin
         o_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  new_r   <= i_price;
                  old_r   <= fill[L] ? sample_mem[wptr] : '0;
                  wptr    <= wptr + L'(1);
                  if (!fill[L]) begin
                     fill <= fill + (L+1)'(1);
                  end
                  o_ready <= 1'b0;
                  state   <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               sum   <= sum + SW'(new_r) - SW'(old_r);
               sumsq <= sumsq + QW'(new_sq) - QW'(old_sq);
               if (fill[L]) begin
                  o_warm <= 1'b1;
                  state  <= S_CALC;
               end else begin
                  o_ready <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            S_CALC: begin
               o_rad      <= var_sat ? '1 : var_scaled[WIDTH-1:0];
               o_overflow <= var_sat;
`ifdef ROLLING_VARIANCE_MEAN_OUT_EN
               o_mean     <= mean;
`endif
               state      <= S_ISSUE;
            end
            S_ISSUE: begin
               if (!i_sqrt_busy) begin
                  o_start <= 1'b1;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_sqrt_valid) begin
                  o_ready <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: begin
               o_ready <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
